// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: per-stage stall generation, trap/mret sequencing, interrupt priority.
// Optional WFI sleep state enabled by defining TRAP_CTRL_WFI_EN.
module trap_ctrl #(
  parameter int              NUM_STAGES = 6,
  parameter int              NUM_LIRQ   = 4,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic [7:0]            exception_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       ins_i,
  input  logic [XLEN-1:0]       mem_addr_i,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  mstatus_ie_i,
  input  logic [2:0]            mie_std_i,
  input  logic [2:0]            mip_std_i,
  input  logic [NUM_LIRQ-1:0]   mie_lirq_i,
  input  logic [NUM_LIRQ-1:0]   mip_lirq_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic [XLEN-1:0]       epc_i,
  output logic                  ie_type_o,
  output logic                  set_cause_o,
  output logic [4:0]            trap_cause_o,
  output logic                  set_epc_o,
  output logic [XLEN-1:0]       epc_o,
  output logic                  set_mtval_o,
  output logic [XLEN-1:0]       mtval_o,
  output logic                  mstatus_ie_clear_o,
  output logic                  mstatus_ie_set_o,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [XLEN-1:0]       new_pc_o
);

  localparam int LIRQ_W = (NUM_LIRQ > 0) ? NUM_LIRQ : 1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_OPERATING,
    ST_TRAP_TAKEN,
    ST_TRAP_RETURN
`ifdef TRAP_CTRL_WFI_EN
    , ST_WFI
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [4:0]      r_cause;
  logic            r_ie_type;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_mtval;
  logic            r_mtval_we;

  logic w_mret, w_ecall, w_ebreak, w_mis_inst, w_illegal, w_mis_store, w_mis_load;
  assign {w_mis_load, w_mis_store, w_illegal, w_mis_inst, w_ebreak, w_ecall, w_mret} = exception_i[6:0];
`ifndef TRAP_CTRL_WFI_EN
  logic w_unused_wfi;
  assign w_unused_wfi = exception_i[7];
`endif

  // Every stage at or below the highest requesting stage must hold.
  logic [NUM_STAGES-1:0] w_stall_req;
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stall
    assign w_stall_req[gi] = |stallreq_i[NUM_STAGES-1:gi];
  end

  logic [LIRQ_W-1:0] w_lirq_hit;
  if (NUM_LIRQ > 0) begin : g_lirq
    for (genvar gi = 0; gi < NUM_LIRQ; gi++) begin : g_bit
      assign w_lirq_hit[gi] = mie_lirq_i[gi] & mip_lirq_i[gi];
    end
  end else begin : g_no_lirq
    assign w_lirq_hit = '0;
  end

  logic [2:0] w_std_hit;
  logic       w_irq_any, w_pend, w_trap_evt, w_stall_free, w_accept;
  assign w_std_hit    = mie_std_i & mip_std_i;
  assign w_irq_any    = (|w_std_hit) | (|w_lirq_hit);
  assign w_pend       = mstatus_ie_i & w_irq_any;
  assign w_trap_evt   = w_pend | w_ecall | w_ebreak | w_mis_inst | w_illegal | w_mis_store | w_mis_load;
  assign w_stall_free = (stallreq_i == '0);
  assign w_accept     = (r_state == ST_OPERATING) && w_stall_free && w_trap_evt;

  logic [4:0]      w_cause;
  logic            w_is_irq;
  logic            w_mtval_we;
  logic [XLEN-1:0] w_mtval;
  always_comb begin
    w_cause    = 5'd0;
    w_is_irq   = 1'b0;
    w_mtval_we = 1'b0;
    w_mtval    = '0;
    if (w_pend) begin
      w_is_irq = 1'b1;
      if (|w_lirq_hit) begin
        // Ascending scan so the highest-numbered local line wins.
        for (int i = 0; i < NUM_LIRQ; i++) begin
          if (w_lirq_hit[i]) w_cause = 5'(16 + i);
        end
      end else if (w_std_hit[2]) w_cause = 5'd11;
      else if (w_std_hit[0])     w_cause = 5'd3;
      else                       w_cause = 5'd7;
    end else if (w_mis_inst) begin
      w_cause = 5'd0;  w_mtval_we = 1'b1; w_mtval = pc_i;
    end else if (w_illegal) begin
      w_cause = 5'd2;  w_mtval_we = 1'b1; w_mtval = ins_i;
    end else if (w_ebreak) begin
      w_cause = 5'd3;  w_mtval_we = 1'b1; w_mtval = pc_i;
    end else if (w_mis_store) begin
      w_cause = 5'd6;  w_mtval_we = 1'b1; w_mtval = mem_addr_i;
    end else if (w_mis_load) begin
      w_cause = 5'd4;  w_mtval_we = 1'b1; w_mtval = mem_addr_i;
    end else if (w_ecall) begin
      w_cause = 5'd11;
    end
  end

  logic [XLEN-1:0] w_base, w_vec_off, w_trap_pc;
  assign w_base    = {mtvec_i[XLEN-1:2], 2'b00};
  assign w_vec_off = {{(XLEN-7){1'b0}}, r_cause, 2'b00};
  assign w_trap_pc = ((mtvec_i[1:0] == 2'b01) && r_ie_type) ? (w_base + w_vec_off) : w_base;

  always_comb begin
    w_state_next       = r_state;
    stall_o            = w_stall_req;
    flush_o            = 1'b0;
    new_pc_o           = '0;
    set_cause_o        = 1'b0;
    set_epc_o          = 1'b0;
    set_mtval_o        = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_next = ST_OPERATING;
        stall_o      = '0;
        new_pc_o     = RESET_PC;
      end
      ST_OPERATING: begin
        if (w_stall_free) begin
          if (w_trap_evt)  w_state_next = ST_TRAP_TAKEN;
          else if (w_mret) w_state_next = ST_TRAP_RETURN;
`ifdef TRAP_CTRL_WFI_EN
          else if (exception_i[7]) w_state_next = ST_WFI;
`endif
        end
      end
      ST_TRAP_TAKEN: begin
        w_state_next       = ST_OPERATING;
        flush_o            = 1'b1;
        new_pc_o           = w_trap_pc;
        set_cause_o        = 1'b1;
        set_epc_o          = 1'b1;
        set_mtval_o        = r_mtval_we;
        mstatus_ie_clear_o = 1'b1;
      end
      ST_TRAP_RETURN: begin
        w_state_next     = ST_OPERATING;
        flush_o          = 1'b1;
        new_pc_o         = epc_i;
        mstatus_ie_set_o = 1'b1;
      end
`ifdef TRAP_CTRL_WFI_EN
      ST_WFI: begin
        stall_o = '1;
        // Wake ignores the global enable; the trap itself still needs it.
        if (w_irq_any) w_state_next = ST_OPERATING;
      end
`endif
      default: w_state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state    <= ST_RESET;
      r_cause    <= 5'd0;
      r_ie_type  <= 1'b0;
      r_epc      <= '0;
      r_mtval    <= '0;
      r_mtval_we <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cause    <= w_cause;
        r_ie_type  <= w_is_irq;
        r_epc      <= pc_i;
        r_mtval    <= w_mtval;
        r_mtval_we <= w_mtval_we;
      end
    end
  end

  assign trap_cause_o = r_cause;
  assign ie_type_o    = r_ie_type;
  assign epc_o        = r_epc;
  assign mtval_o      = r_mtval;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised successor to the core control unit. Generates per-stage pipeline stalls from a stall-request vector of configurable depth and runs the machine-mode trap state machine. Adds a configurable number of platform-local interrupts (causes 16+i), ebreak trapping, a faulting-address mtval and trap deferral while the pipeline is stalled. Sits between the pipeline stages and the CSR unit.

Parameters:
NUM_STAGES, 6, pipeline stage count; width of stallreq_i and stall_o (bit 0 = PC).
NUM_LIRQ, 4, number of local interrupts, legal range 0..16.
XLEN, 32, data/address width.
RESET_PC, 32'h0000_0000, new_pc_o value in the RESET state.

Ports:
clk_i  in  1  core clock
n_rst_i  in  1  reset, asynchronous, active-low
exception_i  in  8  {wfi, misaligned_load, misaligned_store, illegal_inst, misaligned_inst, ebreak, ecall, mret}
pc_i  in  XLEN  PC of the excepting instruction
ins_i  in  XLEN  instruction word
mem_addr_i  in  XLEN  load/store effective address
stallreq_i  in  NUM_STAGES  stall request; bit j comes from stage j
mstatus_ie_i  in  1  global interrupt enable
mie_std_i  in  3  {external, timer, software} enables
mip_std_i  in  3  {external, timer, software} pending
mie_lirq_i  in  NUM_LIRQ  local enables
mip_lirq_i  in  NUM_LIRQ  local pending
mtvec_i  in  XLEN  trap vector
epc_i  in  XLEN  mepc, used by mret
ie_type_o  out  1  1 = interrupt, 0 = exception
set_cause_o  out  1  mcause write strobe
trap_cause_o  out  5  cause code
set_epc_o  out  1  mepc write strobe
epc_o  out  XLEN  value for mepc
set_mtval_o  out  1  mtval write strobe
mtval_o  out  XLEN  value for mtval
mstatus_ie_clear_o  out  1  clear MIE
mstatus_ie_set_o  out  1  set MIE
stall_o  out  NUM_STAGES  per-stage stall
flush_o  out  1  flush the whole pipeline
new_pc_o  out  XLEN  redirect PC, valid only while flush_o=1

Behaviour:
- Reset (async, n_rst_i=0): state RESET. stall_o=0, flush_o=0, all strobes=0, trap_cause_o=0, ie_type_o=0, epc_o=0, mtval_o=0, new_pc_o=RESET_PC.
- Stalls (combinational): j = highest set bit of stallreq_i; stall_o[k]=1 for all k<=j; stall_o=0 when stallreq_i=0. stall_o is forced to 0 in RESET.
- Pending interrupt: pend = mstatus_ie_i & |(mie & mip), across the standard and local bits.
- Trap event: pend | ecall | ebreak | misaligned_inst | illegal_inst | misaligned_store | misaligned_load.
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - RESET -> OPERATING after one cycle.
  - OPERATING -> TRAP_TAKEN on a trap event when stallreq_i==0.
  - Otherwise OPERATING -> TRAP_RETURN on mret when stallreq_i==0.
  - TRAP_TAKEN and TRAP_RETURN -> OPERATING after exactly one cycle.
- Deferral: while stallreq_i!=0, traps and mret are not accepted. The source holds the event until it is accepted.
- Simultaneous trap and mret: the trap wins.
- Capture: cause, ie_type, epc_o=pc_i and mtval are registered on the accepting cycle. Latency is 1 cycle: the strobes and flush appear in the following cycle.
- Priority, highest first, with cause codes:
  1. Local irq NUM_LIRQ-1 down to 0: cause 16+i.
  2. External: 11.
  3. Software: 3.
  4. Timer: 7.
  5. misaligned_inst: 0, mtval=pc_i.
  6. illegal_inst: 2, mtval=ins_i.
  7. ebreak: 3, mtval=pc_i.
  8. misaligned_store: 6, mtval=mem_addr_i.
  9. misaligned_load: 4, mtval=mem_addr_i.
  10. ecall: 11, no mtval write.
- Interrupts never write mtval.
- TRAP_TAKEN outputs (one cycle each): flush_o=1, set_epc_o=1, set_cause_o=1, mstatus_ie_clear_o=1, and set_mtval_o=1 if the trap writes mtval.
- TRAP_TAKEN new_pc_o: base={mtvec_i[XLEN-1:2],2'b00}. If mtvec_i[1:0]==2'b01 and the trap is an interrupt, new_pc_o=base+(cause<<2); otherwise base. Modes 2'b10 and 2'b11 are treated as direct.
- TRAP_RETURN outputs: flush_o=1, new_pc_o=epc_i, mstatus_ie_set_o=1. All other strobes are 0.
- OPERATING: all strobes 0, flush_o=0, new_pc_o=0.
- Reset asserted mid-trap: returns to RESET asynchronously and no strobe completes.

Optional Feature:
TRAP_CTRL_WFI_EN
- Defined: adds a state WFI. In OPERATING, the wfi bit with stallreq_i==0 enters WFI.
- In WFI: stall_o = all ones (NUM_STAGES bits).
- WFI exit: on |(mie & mip), with mstatus_ie_i ignored, the block returns to OPERATING and the stall is released the next cycle.
- If pend is also true on exit, the following cycle enters TRAP_TAKEN as normal.
- Undefined: the wfi bit is ignored (NOP) and the WFI state does not exist.

Test Plan:
- Reset release -> one cycle of new_pc_o=RESET_PC, then OPERATING with all strobes 0.
- stallreq_i=6'b000100 -> stall_o=6'b000111; 6'b010100 -> 6'b011111; 0 -> 0.
- mtvec_i=32'h8000_0101 (vectored), mstatus_ie_i=1, local irq 2 pending and enabled -> next cycle: flush_o=1, trap_cause_o=18, ie_type_o=1, new_pc_o=32'h8000_0148, set_mtval_o=0, mstatus_ie_clear_o=1.
- misaligned_load with mem_addr_i=32'h0000_1003 and stallreq_i[4]=1 for 3 cycles -> no trap during the stall; one cycle after release: cause 4, mtval_o=32'h0000_1003, new_pc_o=32'h8000_0100.
- mret and illegal_inst in the same cycle -> TRAP_TAKEN, cause 2, mtval_o=ins_i; then mret alone with epc_i=32'h200 -> new_pc_o=32'h200, mstatus_ie_set_o=1.
- TRAP_CTRL_WFI_EN: wfi, then timer pending with mstatus_ie_i=0 -> stall_o=all ones until mip&mie, then back to OPERATING with no trap taken.
